// File: rtl/mem_controller_pkg.sv
// Shared bus encodings, FSM state codes and request bundle for mem_controller.
// Used by mem_controller and mem_lane_align.
package mem_controller_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  localparam logic [1:0] BUS_ACC_1B = 2'd0;
  localparam logic [1:0] BUS_ACC_2B = 2'd1;
  localparam logic [1:0] BUS_ACC_4B = 2'd2;

  localparam logic [1:0] MEMC_ST_IDLE   = 2'd0;
  localparam logic [1:0] MEMC_ST_WAIT   = 2'd1;
  localparam logic [1:0] MEMC_ST_ACCESS = 2'd2;

  typedef struct packed {
    logic        w;
    logic [1:0]  acc;
    logic [31:0] wdata;
  } memc_cmd_t;

  // Misaligned offset or reserved size encoding.
  function automatic logic acc_bad(
    input logic [1:0] off,
    input logic [1:0] acc
  );
    return (acc == 2'd3)
        || (off[0] && acc != BUS_ACC_1B)
        || (off[1] && acc == BUS_ACC_4B);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane extraction for reads, byte-enable and
// replicated write data for writes.
module mem_lane_align
  import mem_controller_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  acc,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wrep
);

  always_comb begin
    rdata = '0;
    be    = '0;
    wrep  = '0;
    unique case (1'b1)
      (acc == BUS_ACC_1B): begin
        rdata = {24'b0, word[{off, 3'b000} +: 8]};
        be    = 4'b0001 << off;
        wrep  = {4{wdata[7:0]}};
      end
      (acc == BUS_ACC_2B): begin
        rdata = {16'b0, word[{off[1], 4'b0000} +: 16]};
        be    = 4'b0011 << {off[1], 1'b0};
        wrep  = {2{wdata[15:0]}};
      end
      (acc == BUS_ACC_4B): begin
        rdata = word;
        be    = 4'b1111;
        wrep  = wdata;
      end
      default: begin
        rdata = '0;
        be    = '0;
        wrep  = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// Parametrised on-chip ROM/RAM bus slave with wait states.
// Optional last-read-word buffer enabled by MEMC_RDBUF_EN.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int    AW          = 12,
  parameter int    WAIT_STATES = 0,
  parameter int    WRITABLE    = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [AW-1:0]            addr,
  input  logic                     w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] acc,
  input  logic [BUS_WIDTH-1:0]     wdata,
  input  logic                     req,
  output logic [BUS_WIDTH-1:0]     rdata,
  output logic                     resp,
  output logic                     fault
);

  localparam int DEPTH = 1 << (AW - 2);
  localparam logic [3:0] TC =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit SLOW = (WAIT_STATES > 0);
  localparam bit RW   = (WRITABLE != 0);

  logic [31:0]   mem [DEPTH];
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] a_q;
  memc_cmd_t     cmd_q;

  logic          idle;
  logic          invld;
  logic          accept;
  logic          go_wait;
  logic          wr_en;
  logic [AW-3:0] idx;
  logic [31:0]   word;
  logic [31:0]   rd_al;
  logic [31:0]   wrep;
  logic [3:0]    be;

  assign idle   = (state == MEMC_ST_IDLE);
  assign invld  = acc_bad(addr[1:0], acc) | (w_rb & ~RW);
  assign fault  = req & invld & idle;
  assign accept = req & ~invld & idle;
  assign idx    = a_q[AW-1:2];
  assign wr_en  = rstn & RW & cmd_q.w
                & (state == MEMC_ST_ACCESS);

  mem_lane_align u_align (
    .off   (a_q[1:0]),
    .acc   (cmd_q.acc),
    .word  (word),
    .wdata (cmd_q.wdata),
    .rdata (rd_al),
    .be    (be),
    .wrep  (wrep)
  );

`ifdef MEMC_RDBUF_EN
  logic          rb_vld;
  logic [AW-3:0] rb_tag;
  logic [31:0]   rb_data;
  logic          hit;
  logic          hit_q;

  assign hit     = rb_vld & ~w_rb & (rb_tag == addr[AW-1:2]);
  assign go_wait = SLOW & ~hit;
  assign word    = hit_q ? rb_data : mem[idx];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rb_vld  <= 1'b0;
      rb_tag  <= '0;
      rb_data <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (accept) hit_q <= hit;
      if (state == MEMC_ST_ACCESS && !cmd_q.w) begin
        rb_vld  <= 1'b1;
        rb_tag  <= idx;
        rb_data <= word;
      end else if (wr_en && rb_vld && rb_tag == idx) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) rb_data[8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end
`else
  assign go_wait = SLOW;
  assign word    = mem[idx];
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= MEMC_ST_IDLE;
      cnt   <= '0;
      resp  <= 1'b0;
      rdata <= '0;
      a_q   <= '0;
      cmd_q <= '0;
    end else begin
      resp <= 1'b0;
      unique case (1'b1)
        (state == MEMC_ST_IDLE): begin
          if (accept) begin
            a_q   <= addr;
            cmd_q <= '{w: w_rb, acc: acc, wdata: wdata};
            cnt   <= '0;
            state <= go_wait ? MEMC_ST_WAIT : MEMC_ST_ACCESS;
          end
        end
        (state == MEMC_ST_WAIT): begin
          if (cnt == TC) state <= MEMC_ST_ACCESS;
          else           cnt   <= cnt + 4'd1;
        end
        (state == MEMC_ST_ACCESS): begin
          if (!cmd_q.w) rdata <= rd_al;
          resp  <= 1'b1;
          state <= MEMC_ST_IDLE;
        end
        default: state <= MEMC_ST_IDLE;
      endcase
    end
  end

endmodule
